adc_i2s_rx: RTL and testbench

ADC_I2S_RX -- requirements
Module: adc_i2s_rx

---
 rtl/adc_i2s_rx.sv | 153 +++++++++++++++
 tb/tb_adc_i2s_rx.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_i2s_rx.sv
// I2S ADC receiver: oversamples BCLK/LRCK/DATA in the Clk domain, emits {left,right} frames
// through a one-entry output buffer. Define ADC_I2S_RX_OVF_CNT_EN to add the Overrun_Count output.
module adc_i2s_rx #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    AUD_BCLK,
   input  logic                    AUD_ADCLRCK,
   input  logic                    AUD_ADCDAT,
   output logic [2*DATA_WIDTH-1:0] ADCDATA,
   output logic                    Sample_Valid,
   input  logic                    Sample_Ready,
   output logic                    Overrun,
   output logic                    Frame_Err
`ifdef ADC_I2S_RX_OVF_CNT_EN
   ,
   output logic [7:0]              Overrun_Count
`endif
);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {ALIGN, SKIP, SHIFT, HOLD} state_t;

   state_t                  state;
   logic                    chan;       // 0 = left, 1 = right
   logic                    left_ok;    // a complete left word waits for its right partner
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   shreg;
   logic [DATA_WIDTH-1:0]   left_word;

   // [1:0] is the 2-flop synchronizer, [2] is the previous synchronized value for edge detect
   logic [2:0]              bclk_sync;
   logic [2:0]              lrck_sync;
   logic [1:0]              dat_sync;

   logic                    bclk_rise;
   logic                    lrck_edge;
   logic                    lrck_fall;
   logic                    last_bit;
   logic                    complete;
   logic [DATA_WIDTH-1:0]   word;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         bclk_sync <= '0;
         lrck_sync <= '0;
         dat_sync  <= '0;
      end else begin
         bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
         lrck_sync <= {lrck_sync[1:0], AUD_ADCLRCK};
         dat_sync  <= {dat_sync[0], AUD_ADCDAT};
      end
   end

   assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
   assign lrck_edge = lrck_sync[1] ^ lrck_sync[2];
   assign lrck_fall = ~lrck_sync[1] & lrck_sync[2];
   assign last_bit  = (cnt == CW'(DATA_WIDTH - 1));
   assign word      = {shreg[DATA_WIDTH-2:0], dat_sync[1]};
   assign complete  = (state == SHIFT) && !lrck_edge && bclk_rise && last_bit && chan && left_ok;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= ALIGN;
         chan      <= 1'b0;
         left_ok   <= 1'b0;
         cnt       <= '0;
         shreg     <= '0;
         left_word <= '0;
         Frame_Err <= 1'b0;
      end else begin
         Frame_Err <= 1'b0;
         case (state)
            ALIGN: begin
               if (lrck_fall) begin
                  state   <= SKIP;
                  chan    <= 1'b0;
                  cnt     <= '0;
                  left_ok <= 1'b0;
               end
            end
            SKIP, SHIFT: begin
               if (lrck_edge) begin
                  // early word-clock toggle: the whole channel pair is lost
                  Frame_Err <= 1'b1;
                  chan      <= lrck_sync[1];
                  cnt       <= '0;
                  shreg     <= '0;
                  left_ok   <= 1'b0;
                  state     <= SKIP;
               end else if (bclk_rise) begin
                  if (state == SKIP) begin
                     state <= SHIFT;
                  end else begin
                     shreg <= word;
                     cnt   <= cnt + 1'b1;
                     if (last_bit) begin
                        state <= HOLD;
                        cnt   <= '0;
                        if (!chan) begin
                           left_word <= word;
                           left_ok   <= 1'b1;
                        end else begin
                           left_ok   <= 1'b0;
                        end
                     end
                  end
               end
            end
            HOLD: begin
               if (lrck_edge) begin
                  chan  <= lrck_sync[1];
                  cnt   <= '0;
                  shreg <= '0;
                  state <= SKIP;
               end
            end
            default: state <= ALIGN;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ADCDATA      <= '0;
         Sample_Valid <= 1'b0;
         Overrun      <= 1'b0;
      end else begin
         Overrun <= 1'b0;
         if (complete) begin
            if (!Sample_Valid || Sample_Ready) begin
               ADCDATA      <= {left_word, word};
               Sample_Valid <= 1'b1;
            end else begin
               Overrun <= 1'b1;
            end
         end else if (Sample_Valid && Sample_Ready) begin
            Sample_Valid <= 1'b0;
         end
      end
   end

`ifdef ADC_I2S_RX_OVF_CNT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset)
         Overrun_Count <= 8'd0;
      else if (Overrun && Overrun_Count != 8'hFF)
         Overrun_Count <= Overrun_Count + 8'd1;
   end
`endif

endmodule

// File: tb/tb_adc_i2s_rx.sv
// Bench for adc_i2s_rx: drives an I2S codec model, scoreboards accepted frames against
// expected frames, and checks overrun/frame-error pulses and reset behaviour.
module tb_adc_i2s_rx;
   localparam int W = 16;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           bclk = 1'b0;
   logic           lrck = 1'b0;
   logic           dat = 1'b0;
   logic           rdy = 1'b0;
   logic [2*W-1:0] adcdata;
   logic           vld;
   logic           ovr;
   logic           ferr;
`ifdef ADC_I2S_RX_OVF_CNT_EN
   logic [7:0]     ovf_cnt;
`endif

   adc_i2s_rx #(.DATA_WIDTH(W)) dut (
      .Clk          (clk),
      .Reset        (rst_n),
      .AUD_BCLK     (bclk),
      .AUD_ADCLRCK  (lrck),
      .AUD_ADCDAT   (dat),
      .ADCDATA      (adcdata),
      .Sample_Valid (vld),
      .Sample_Ready (rdy),
      .Overrun      (ovr),
      .Frame_Err    (ferr)
`ifdef ADC_I2S_RX_OVF_CNT_EN
      ,
      .Overrun_Count(ovf_cnt)
`endif
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [W-1:0]   left;
      logic [W-1:0]   right;
      logic [2*W-1:0] expd;
   } vec_t;

   vec_t           vecs[5];
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] obs_q[$];
   int             checks = 0;
   int             errors = 0;
   int             ovr_cnt = 0;
   int             ferr_cnt = 0;

   // consumer-side monitor: every handshake cycle hands one frame to the scoreboard
   always @(negedge clk) begin
      if (vld && rdy) obs_q.push_back(adcdata);
      if (ovr) ovr_cnt <= ovr_cnt + 1;
      if (ferr) ferr_cnt <= ferr_cnt + 1;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // one BCLK period; data/LRCK change while BCLK is low. rdy_pulse raises Sample_Ready
   // for exactly the Clk edge that acts on this bit's rising edge.
   task automatic bit_cycle(input logic lr, input logic d, input bit rdy_pulse);
      bclk = 1'b0;
      lrck = lr;
      dat  = d;
      tick(8);
      bclk = 1'b1;
      if (rdy_pulse) begin
         tick(2);
         rdy = 1'b1;
         tick(1);
         rdy = 1'b0;
         tick(5);
      end else begin
         tick(8);
      end
   endtask

   task automatic send_half(input logic lr, input logic [W-1:0] w, input int nbits,
                            input int total, input bit rdy_lsb);
      bit_cycle(lr, 1'b0, 1'b0);
      for (int i = 0; i < nbits; i++) bit_cycle(lr, w[W-1-i], rdy_lsb && (i == W - 1));
      for (int i = nbits + 1; i < total; i++) bit_cycle(lr, 1'b0, 1'b0);
   endtask

   task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r, input bit rdy_lsb);
      send_half(1'b0, l, W, W + 2, 1'b0);
      send_half(1'b1, r, W, W + 2, rdy_lsb);
   endtask

   task automatic drain(input string name, input int n);
      logic [2*W-1:0] e;
      check({name, " count"}, obs_q.size(), n);
      while (obs_q.size() > 0) begin
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
         check({name, " data"}, obs_q.pop_front(), e);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, " ADCDATA"}, adcdata, 0);
      check({name, " Sample_Valid"}, vld, 0);
      check({name, " Overrun"}, ovr, 0);
      check({name, " Frame_Err"}, ferr, 0);
   endtask

   initial begin
      vecs[0] = '{16'hA5C3, 16'h0F1E, 32'hA5C30F1E};
      vecs[1] = '{16'h0000, 16'hFFFF, 32'h0000FFFF};
      vecs[2] = '{16'hFFFF, 16'h0000, 32'hFFFF0000};
      vecs[3] = '{16'h8001, 16'h7FFE, 32'h80017FFE};
      vecs[4] = '{16'h1234, 16'h5678, 32'h12345678};

      tick(5);
      check_zero("in reset");
      rst_n = 1'b1;
      tick(3);

      // right word before any LRCK falling edge must be ignored
      send_half(1'b1, 16'hFFFF, W, W + 2, 1'b0);
      rdy = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(vecs[i].expd);
         send_frame(vecs[i].left, vecs[i].right, 1'b0);
         tick(4);
         drain("table frame", 1);
      end
      check("table Overrun pulses", ovr_cnt, 0);
      check("table Frame_Err pulses", ferr_cnt, 0);
      tick(4);
      check("idle Sample_Valid", vld, 0);

      // consumer stalled: second frame dropped
      rdy = 1'b0;
      exp_q.push_back(32'h11112222);
      send_frame(16'h1111, 16'h2222, 1'b0);
      send_frame(16'h3333, 16'h4444, 1'b0);
      check("stall ADCDATA", adcdata, 32'h11112222);
      check("stall Sample_Valid", vld, 1);
      check("stall Overrun pulses", ovr_cnt, 1);
`ifdef ADC_I2S_RX_OVF_CNT_EN
      check("stall Overrun_Count", ovf_cnt, 1);
`endif
      drain("stall", 0);

      // accept in the completion cycle: new frame replaces held one, valid stays high
      exp_q.push_back(32'h55556666);
      send_frame(16'h5555, 16'h6666, 1'b1);
      check("handoff ADCDATA", adcdata, 32'h55556666);
      check("handoff Sample_Valid", vld, 1);
      check("handoff Overrun pulses", ovr_cnt, 1);
      drain("handoff", 1);
      rdy = 1'b1;
      tick(4);
      check("handoff cleared", vld, 0);
      drain("handoff accept", 1);

      // LRCK toggles after 9 left bits
      send_half(1'b0, 16'h9999, 9, 10, 1'b0);
      send_half(1'b1, 16'hAAAA, W, W + 2, 1'b0);
      check("abort Frame_Err pulses", ferr_cnt, 1);
      drain("abort", 0);
      exp_q.push_back(32'h77778888);
      send_frame(16'h7777, 16'h8888, 1'b0);
      tick(4);
      drain("after abort", 1);
      check("after abort Frame_Err pulses", ferr_cnt, 1);

      // reset mid right channel
      send_half(1'b0, 16'hCAFE, W, W + 2, 1'b0);
      send_half(1'b1, 16'hBEEF, 8, 8, 1'b0);
      rst_n = 1'b0;
      tick(3);
      check_zero("mid reset");
`ifdef ADC_I2S_RX_OVF_CNT_EN
      check("mid reset Overrun_Count", ovf_cnt, 0);
`endif
      rst_n = 1'b1;
      tick(3);
      send_half(1'b1, 16'h1234, W, W + 2, 1'b0);
      exp_q.push_back(32'hDEADBEEF);
      send_frame(16'hDEAD, 16'hBEEF, 1'b0);
      tick(4);
      drain("realign", 1);
      check("realign Frame_Err pulses", ferr_cnt, 1);
      check("realign Overrun pulses", ovr_cnt, 1);
      check("scoreboard empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
